apb_master_ctrl: RTL and testbench

//   APB requester. Takes single read/write commands on a valid/ready request port, drives APB

---
 rtl/apb_master_pkg.sv | 31 +++
 rtl/apb_timeout_counter.sv | 39 +++
 rtl/apb_master_ctrl.sv | 147 ++++++++++++++
 tb/tb_apb_master_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types for the APB requester: FSM state encoding, command/response
// records at the default bus widths, and those default widths.
package apb_master_pkg;

    localparam int unsigned APB_ADDR_W         = 16;
    localparam int unsigned APB_DATA_W         = 32;
    localparam int unsigned APB_STRB_W         = APB_DATA_W / 8;
    localparam int unsigned APB_TIMEOUT_CYCLES = 256;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
        logic                  prot;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase watchdog for apb_master_ctrl; present only when APB_TIMEOUT_EN
// is defined. expired_o flags the enabled cycle that reaches LIMIT.
`ifdef APB_TIMEOUT_EN
module apb_timeout_counter #(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] count_q, count_d;

    // Expiry is combinational so the FSM leaves ACCESS on the limit edge itself.
    assign expired_o = enable_i && (count_q == CNT_W'(LIMIT - 1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`endif

// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS on APB,
// valid/ready response out. Define APB_TIMEOUT_EN to enable the ACCESS watchdog.
module apb_master_ctrl
    import apb_master_pkg::*;
#(
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    input  logic                cmd_prot,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic                pprot,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic                pready,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pslverr
);

    localparam int unsigned STRB_W = DATA_W / 8;

    if (TIMEOUT_CYCLES < 1 || (DATA_W % 8) != 0) begin : g_param_check
        $error("apb_master_ctrl: TIMEOUT_CYCLES must be >= 1 and DATA_W a multiple of 8");
    end

    apb_state_e state_q, state_d;

    logic                pwrite_q, pprot_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [STRB_W-1:0]   pstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q, timeout_q;
    logic                accept;
    logic                timeout_hit;

    assign accept = cmd_valid && cmd_ready;

`ifdef APB_TIMEOUT_EN
    apb_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (state_q == SETUP),
        .enable_i ((state_q == ACCESS) && !pready),
        .expired_o(timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready || timeout_hit) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // cmd_ready is also masked by rst so nothing is offered while reset is held.
    always_comb begin
        cmd_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            IDLE:    cmd_ready = !rst;
            SETUP:   psel      = 1'b1;
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwrite_q  <= 1'b0;
            pprot_q   <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                pwrite_q <= cmd_write;
                pprot_q  <= cmd_prot;
                paddr_q  <= cmd_addr;
                pwdata_q <= cmd_wdata;
                pstrb_q  <= cmd_write ? cmd_strb : '0;
            end
            if (state_q == ACCESS) begin
                if (pready) begin
                    rdata_q   <= pwrite_q ? '0 : prdata;
                    err_q     <= pslverr;
                    timeout_q <= 1'b0;
                end else if (timeout_hit) begin
                    rdata_q   <= '0;
                    err_q     <= 1'b1;
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign pwrite      = pwrite_q;
    assign pprot       = pprot_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl with a scoreboard-checked response port and
// a reactive APB slave; the watchdog vector is included when APB_TIMEOUT_EN is set.
module tb_apb_master_ctrl;
    import apb_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, cmd_prot = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite, pprot;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready = 1'b0, pslverr = 1'b0;
    logic [31:0] prdata = '0;

    apb_master_ctrl #(
        .ADDR_W(16),
        .DATA_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pprot(pprot),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    apb_rsp_t sb[$];

    typedef struct {
        apb_cmd_t    cmd;
        int unsigned slv_wait;
        bit          slv_err;
        int unsigned n_access;
        int unsigned hold;
        apb_rsp_t    exp;
    } vec_t;

    vec_t vecs[$];

    int unsigned slv_wait = 0;
    bit          slv_err  = 1'b0;
    logic [31:0] mem [logic [15:0]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit w, input logic [15:0] a, input logic [31:0] d,
                                input logic [3:0] s, input bit p, input int unsigned sw,
                                input bit se, input int unsigned na, input int unsigned h,
                                input logic [31:0] er, input bit ee, input bit et);
        vec_t v;
        v.cmd      = '{write: w, addr: a, wdata: d, strb: s, prot: p};
        v.slv_wait = sw;
        v.slv_err  = se;
        v.n_access = na;
        v.hold     = h;
        v.exp      = '{rdata: er, err: ee, timeout: et};
        return v;
    endfunction

    // Reactive slave: completes after slv_wait stalled ACCESS cycles; junk elsewhere.
    initial begin : slave
        int unsigned acc_cnt;
        logic [31:0] w;
        acc_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (psel && penable) begin
                if (acc_cnt >= slv_wait) begin
                    pready  = 1'b1;
                    pslverr = slv_err;
                    if (pwrite) begin
                        prdata = $urandom;
                        w = mem.exists(paddr) ? mem[paddr] : 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (pstrb[b]) w[8*b +: 8] = pwdata[8*b +: 8];
                        mem[paddr] = w;
                    end else begin
                        prdata = mem.exists(paddr) ? mem[paddr] : 32'h0;
                    end
                end else begin
                    pready  = 1'b0;
                    pslverr = 1'($urandom);
                    prdata  = $urandom;
                    acc_cnt++;
                end
            end else begin
                acc_cnt = 0;
                pready  = 1'($urandom);
                pslverr = 1'($urandom);
                prdata  = $urandom;
            end
        end
    end

    // Response monitor: every cycle a response is shown it must match the head entry.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL rsp_unexpected at %0t: got rdata 0x%0h err %0b timeout %0b, want no response",
                             $time, rsp_rdata, rsp_err, rsp_timeout);
                end else begin
                    if ({rsp_rdata, rsp_err, rsp_timeout} !== sb[0]) begin
                        n_err++;
                        $display("FAIL rsp_data at %0t: got rdata 0x%0h err %0b timeout %0b, want rdata 0x%0h err %0b timeout %0b",
                                 $time, rsp_rdata, rsp_err, rsp_timeout,
                                 sb[0].rdata, sb[0].err, sb[0].timeout);
                    end
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL sim_timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "bench watchdog expired");
    end

    task automatic issue(input apb_cmd_t c, output bit ok);
        int unsigned n;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_write = c.write;
        cmd_addr  = c.addr;
        cmd_wdata = c.wdata;
        cmd_strb  = c.strb;
        cmd_prot  = c.prot;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 20);
        ok = cmd_ready;
        if (!ok) chk("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_wdata = $urandom;
        cmd_addr  = 16'($urandom);
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        slv_wait  = v.slv_wait;
        slv_err   = v.slv_err;
        rsp_ready = (v.hold == 0);
        sb.push_back(v.exp);
        issue(v.cmd, ok);
        if (!ok) begin
            void'(sb.pop_back());
            return;
        end
        @(negedge clk);
        chk("setup_psel",    64'(psel),    64'd1);
        chk("setup_penable", 64'(penable), 64'd0);
        chk("setup_paddr",   64'(paddr),   64'(v.cmd.addr));
        chk("setup_pwrite",  64'(pwrite),  64'(v.cmd.write));
        chk("setup_pwdata",  64'(pwdata),  64'(v.cmd.wdata));
        chk("setup_pstrb",   64'(pstrb),   v.cmd.write ? 64'(v.cmd.strb) : 64'd0);
        chk("setup_pprot",   64'(pprot),   64'(v.cmd.prot));
        for (int unsigned k = 0; k < v.n_access; k++) begin
            @(negedge clk);
            chk("access_psel_penable", 64'({psel, penable}), 64'd3);
            chk("access_paddr",        64'(paddr),           64'(v.cmd.addr));
            chk("access_rsp_valid",    64'(rsp_valid),       64'd0);
        end
        @(negedge clk);
        chk("resp_valid",   64'(rsp_valid),            64'd1);
        chk("resp_apb_off", 64'({psel, penable}),      64'd0);
        if (v.hold > 0) begin
            for (int unsigned i = 0; i < v.hold; i++) begin
                if (i > 0) @(negedge clk);
                chk("hold_valid",     64'(rsp_valid), 64'd1);
                chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
                chk("hold_psel",      64'(psel),      64'd0);
            end
            @(posedge clk);
            #1;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        chk("back_idle_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("back_idle_rsp_valid", 64'(rsp_valid), 64'd0);
    endtask

    initial begin : stimulus
        bit ok;
        mem[16'h0020] = 32'hCAFE_F00D;

        vecs.push_back(mk(1, 16'h0010, 32'hDEAD_BEEF, 4'hF, 1, 0, 0, 1, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 16'h0010, 32'h1234_5678, 4'hF, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0));
        vecs.push_back(mk(1, 16'h0014, 32'h1122_3344, 4'h5, 0, 3, 0, 4, 0, 32'h0,         0, 0));
        vecs.push_back(mk(0, 16'h0014, 32'h0,         4'hF, 1, 3, 0, 4, 0, 32'h0022_0044, 0, 0));
        vecs.push_back(mk(0, 16'h0020, 32'h0,         4'h0, 0, 0, 1, 1, 0, 32'hCAFE_F00D, 1, 0));
        vecs.push_back(mk(1, 16'h0010, 32'hAA00_0000, 4'h8, 1, 0, 0, 1, 5, 32'h0,         0, 0));
        vecs.push_back(mk(0, 16'h0010, 32'h0,         4'h0, 0, 0, 0, 1, 0, 32'hAAAD_BEEF, 0, 0));
        vecs.push_back(mk(1, 16'h0030, 32'h5555_AAAA, 4'hF, 0, 1, 1, 2, 0, 32'h0,         1, 0));
`ifdef APB_TIMEOUT_EN
        vecs.push_back(mk(0, 16'h0010, 32'h0,         4'h0, 0, 1000, 0, 4, 2, 32'h0,     1, 1));
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("reset_apb_ctrl",  64'({psel, penable, pwrite, pprot}), 64'd0);
        chk("reset_apb_data",  64'({paddr, pwdata, pstrb}), 64'd0);
        chk("reset_rsp",       64'({rsp_valid, rsp_err, rsp_timeout}), 64'd0);
        chk("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset while a read is stalled in ACCESS: nothing may come back afterwards.
        slv_wait  = 1000;
        slv_err   = 1'b0;
        rsp_ready = 1'b1;
        issue('{write: 1'b0, addr: 16'h0040, wdata: 32'h0, strb: 4'h0, prot: 1'b0}, ok);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_in_access", 64'({psel, penable}), 64'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_psel_penable", 64'({psel, penable}), 64'd3);
        @(negedge clk);
        chk("rst_mid_psel_penable_cleared", 64'({psel, penable}), 64'd0);
        chk("rst_mid_rsp_valid",  64'(rsp_valid), 64'd0);
        chk("rst_mid_cmd_ready",  64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("after_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (4) @(negedge clk);

        run_vec(mk(0, 16'h0010, 32'h0, 4'h0, 1, 0, 0, 1, 0, 32'hAAAD_BEEF, 0, 0));

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
